johnson_monitor: RTL and testbench
==================================

Name: johnson_monitor

Overview:
Receive-side checker for the Johnson-code LED chaser bus, which steps through the 2*WIDTH states 0000000, 1000000, 1100000, … 1111111, 0111111, … 0000001 on each prescaler terminal-count tick. The block samples the code on each tick strobe and decodes it to a position index. It locks onto the sequence, flags illegal codes and illegal transitions, and counts completed sweeps. It sits beside the chaser for self-test and drives status LEDs and the debug display.

Parameters:
WIDTH, 7, Johnson register width; sequence length is 2*WIDTH.
LOCK_LEN, 2, consecutive legal advances required to enter LOCKED.
CNT_W, 8, width of the sweep and error counters.

Ports:
CLK  input  1  system clock, rising edge.
RSTn  input  1  asynchronous active-low reset.
ENABLE  input  1  1 = process SAMPLE; 0 = freeze all state and outputs.
SAMPLE  input  1  one-cycle strobe (chaser TC); CODE_IN is valid this cycle.
CODE_IN  input  WIDTH  observed Johnson code, MSB fills first.
POS  output  $clog2(2*WIDTH)  decoded position 0..2*WIDTH-1.
LOCKED  output  1  sequence tracking established.
STEP  output  1  one-cycle pulse per accepted advance while LOCKED.
ERR  output  1  sticky: at least one error seen while LOCKED.
ERR_COUNT  output  CNT_W  errors while LOCKED; saturates at all-ones.
SWEEPS  output  CNT_W  completed full cycles; wraps modulo 2^CNT_W.
DIR  output  1  1 = last accepted step was reverse; tied 0 without macro.

Behaviour:
- Reset (RSTn low, asynchronous): POS=0, LOCKED=0, STEP=0, ERR=0, ERR_COUNT=0, SWEEPS=0, DIR=0, FSM=SEARCH, run counter=0. Reset takes effect mid-sequence with no completion of the pending sample.
- Decode, combinational on CODE_IN:
  - k leading ones from MSB with the rest zero gives index k (0..WIDTH).
  - m trailing ones at LSB with the rest zero, 1<=m<=WIDTH-1, gives index 2*WIDTH-m.
  - Any other pattern is illegal.
- Successor of index i = (i+1) mod 2*WIDTH.
- Sample processing: only when ENABLE=1 and SAMPLE=1. All outputs are registered and update on the CLK edge after the sample cycle (latency 1).
- SEARCH state:
  - Illegal code: run=0, POS unchanged, no error counted.
  - Legal code, not the successor of POS: POS=index, run=0.
  - Successor of POS: POS=index, run=run+1. When run reaches LOCK_LEN, go to LOCKED and set LOCKED=1.
  - Same index as POS: no change.
- LOCKED state:
  - Same index as POS (hold): no change, no STEP.
  - Successor: POS=index, STEP=1 for one cycle. If the step wraps 2*WIDTH-1 -> 0, SWEEPS increments.
  - Illegal code, or a legal but non-successor code: ERR=1, ERR_COUNT+1 (saturating), LOCKED=0, run=0, go to SEARCH. POS loads the index if the code is legal, else holds.
- STEP is low on every cycle other than the cycle after an accepted advance.
- ENABLE=0: SAMPLE is ignored and every register holds. STEP is forced 0.
- ERR clears only on reset.

Optional Feature:
MONITOR_REVERSE_EN.
- Defined: in LOCKED, the predecessor ((i-1) mod 2*WIDTH) is also a legal advance. It pulses STEP and sets DIR=1; a forward advance sets DIR=0. A wrap 0 -> 2*WIDTH-1 also increments SWEEPS. In SEARCH, predecessors count toward lock, provided the run keeps one consistent direction; a direction change restarts the run at 0.
- Undefined: a predecessor is an error like any other non-successor code, and DIR is constant 0.

Test Plan:
- Reset, then feed 0000000, 1000000, 1100000 on three SAMPLE strobes -> LOCKED=1 on the edge after the third sample, POS=2, ERR=0.
- Locked, run a full cycle from 1100000 back around to 1100000 (14 samples) -> 14 STEP pulses, SWEEPS=1, POS=2.
- Locked at POS=5 (1111100), feed 1011000 -> LOCKED=0, ERR=1, ERR_COUNT=1, POS holds 5. Then feed 1111110, 1111111 -> LOCKED=1 again, POS=7.
- Locked at POS=3, feed 1110000 three times -> no STEP, no error, POS=3. Then pulse SAMPLE with ENABLE=0 and CODE_IN=0000001 -> no state change.
- Force 255 lock-break errors in total -> ERR_COUNT=8'hFF and stays there on further errors.
- With MONITOR_REVERSE_EN, locked at POS=0, feed 0000001 -> POS=13, DIR=1, STEP pulse, SWEEPS+1. Without the macro, the same stimulus gives ERR=1 and LOCKED=0.

Source files
------------

// File: rtl/johnson_monitor.sv
// -----------------------------------------------------------------------------
// johnson_monitor
//
// Receive-side checker for a Johnson-code LED chaser bus. On every enabled
// SAMPLE strobe the observed code is decoded to a position index. The block
// locks onto the stepping sequence after LOCK_LEN consecutive legal advances,
// flags illegal codes / illegal transitions while locked, and counts
// completed sweeps around the 2*WIDTH-state ring.
//
// Optional feature macro: MONITOR_REVERSE_EN
//   When defined, a step to the predecessor position is also accepted as a
//   legal (reverse) advance and DIR reports the direction of the last
//   accepted step. When undefined, a predecessor is an error and DIR is 0.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RSTn       in   asynchronous active-low reset
//   ENABLE     in   1 = process SAMPLE, 0 = freeze all state (STEP forced 0)
//   SAMPLE     in   one-cycle strobe, CODE_IN valid this cycle
//   CODE_IN    in   [WIDTH-1:0] observed Johnson code, MSB fills first
//   POS        out  decoded position 0..2*WIDTH-1
//   LOCKED     out  sequence tracking established
//   STEP       out  one-cycle pulse per accepted advance while locked
//   ERR        out  sticky error flag (errors seen while locked)
//   ERR_COUNT  out  [CNT_W-1:0] errors while locked, saturating
//   SWEEPS     out  [CNT_W-1:0] completed full cycles, wrapping
//   DIR        out  1 = last accepted step was reverse
// -----------------------------------------------------------------------------
module johnson_monitor #(
    parameter int WIDTH    = 7,
    parameter int LOCK_LEN = 2,
    parameter int CNT_W    = 8
) (
    input  logic                          CLK,
    input  logic                          RSTn,
    input  logic                          ENABLE,
    input  logic                          SAMPLE,
    input  logic [WIDTH-1:0]              CODE_IN,
    output logic [$clog2(2*WIDTH)-1:0]    POS,
    output logic                          LOCKED,
    output logic                          STEP,
    output logic                          ERR,
    output logic [CNT_W-1:0]              ERR_COUNT,
    output logic [CNT_W-1:0]              SWEEPS,
    output logic                          DIR
);

    localparam int N  = 2 * WIDTH;
    localparam int PW = $clog2(N);
    localparam int RW = (LOCK_LEN > 1) ? $clog2(LOCK_LEN + 1) : 1;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Decode a Johnson code: returns {legal, index}. Leading ones from the
    // MSB give indices 0..WIDTH, trailing ones at the LSB give the falling
    // half of the ring (2*WIDTH-m).
    function automatic logic [PW:0] decode_code(input logic [WIDTH-1:0] code);
        logic [WIDTH-1:0] ones;
        logic [PW:0]      res;
        ones = {WIDTH{1'b1}};
        res  = {(PW+1){1'b0}};
        for (int k = 0; k <= WIDTH; k++) begin
            res = (code == ~(ones >> k)) ? {1'b1, PW'(k)} : res;
        end
        for (int m = 1; m < WIDTH; m++) begin
            res = (code == (ones >> (WIDTH - m))) ? {1'b1, PW'(N - m)} : res;
        end
        return res;
    endfunction

    state_t            state_r, state_nx_s;
    logic [PW-1:0]     pos_r, pos_nx_s;
    logic [RW-1:0]     run_r, run_nx_s;
    logic              step_r, step_nx_s;
    logic              err_r, err_nx_s;
    logic [CNT_W-1:0]  err_count_r, err_count_nx_s;
    logic [CNT_W-1:0]  sweeps_r, sweeps_nx_s;

    logic [PW:0]       dec_s;
    logic              legal_s;
    logic [PW-1:0]     idx_s;
    logic [PW-1:0]     succ_s;
    logic              proc_s;
    logic              is_hold_s;
    logic              is_fwd_s;
    logic              is_rev_s;
    logic              adv_s;
    logic              dir_break_s;
    logic              lock_hit_s;
    logic              wrap_s;

`ifdef MONITOR_REVERSE_EN
    logic [PW-1:0]     pred_s;
    logic              run_dir_r, run_dir_nx_s;
    logic              dir_r, dir_nx_s;
`endif

    assign dec_s     = decode_code(CODE_IN);
    assign legal_s   = dec_s[PW];
    assign idx_s     = dec_s[PW-1:0];
    assign succ_s    = (pos_r == PW'(N - 1)) ? {PW{1'b0}} : pos_r + PW'(1'b1);
    assign proc_s    = ENABLE & SAMPLE;
    assign is_hold_s = legal_s && (idx_s == pos_r);
    assign is_fwd_s  = legal_s && (idx_s == succ_s);

`ifdef MONITOR_REVERSE_EN
    assign pred_s      = (pos_r == {PW{1'b0}}) ? PW'(N - 1) : pos_r - PW'(1'b1);
    assign is_rev_s    = legal_s && (idx_s == pred_s);
    // A lock run must keep one direction; a reversal mid-run restarts it.
    assign dir_break_s = (run_r != {RW{1'b0}}) && (run_dir_r != is_rev_s);
    assign wrap_s      = (is_fwd_s && (idx_s == {PW{1'b0}})) ||
                         (is_rev_s && (idx_s == PW'(N - 1)));
`else
    assign is_rev_s    = 1'b0;
    assign dir_break_s = 1'b0;
    assign wrap_s      = is_fwd_s && (idx_s == {PW{1'b0}});
`endif

    assign adv_s      = is_fwd_s | is_rev_s;
    assign lock_hit_s = adv_s && !dir_break_s && (run_r == RW'(LOCK_LEN - 1));

    // State and datapath registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r     <= ST_SEARCH;
            pos_r       <= {PW{1'b0}};
            run_r       <= {RW{1'b0}};
            step_r      <= 1'b0;
            err_r       <= 1'b0;
            err_count_r <= {CNT_W{1'b0}};
            sweeps_r    <= {CNT_W{1'b0}};
`ifdef MONITOR_REVERSE_EN
            run_dir_r   <= 1'b0;
            dir_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_nx_s;
            pos_r       <= pos_nx_s;
            run_r       <= run_nx_s;
            step_r      <= step_nx_s;
            err_r       <= err_nx_s;
            err_count_r <= err_count_nx_s;
            sweeps_r    <= sweeps_nx_s;
`ifdef MONITOR_REVERSE_EN
            run_dir_r   <= run_dir_nx_s;
            dir_r       <= dir_nx_s;
`endif
        end
    end

    // Next-state logic: lock on the LOCK_LEN-th advance, drop on any break
    always_comb begin
        state_nx_s = state_r;
        if (proc_s) begin
            case (state_r)
                ST_SEARCH: begin
                    if (lock_hit_s) begin
                        state_nx_s = ST_LOCKED;
                    end else begin
                        state_nx_s = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    if (is_hold_s || adv_s) begin
                        state_nx_s = ST_LOCKED;
                    end else begin
                        state_nx_s = ST_SEARCH;
                    end
                end
                default: state_nx_s = ST_SEARCH;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Next values of the registered outputs and the lock run counter
    always_comb begin
        pos_nx_s       = pos_r;
        run_nx_s       = run_r;
        step_nx_s      = 1'b0;
        err_nx_s       = err_r;
        err_count_nx_s = err_count_r;
        sweeps_nx_s    = sweeps_r;
`ifdef MONITOR_REVERSE_EN
        run_dir_nx_s   = run_dir_r;
        dir_nx_s       = dir_r;
`endif
        if (proc_s) begin
            case (state_r)
                ST_SEARCH: begin
                    if (!legal_s) begin
                        run_nx_s = {RW{1'b0}};
                    end else if (is_hold_s) begin
                        run_nx_s = run_r;
                    end else if (adv_s) begin
                        pos_nx_s = idx_s;
`ifdef MONITOR_REVERSE_EN
                        run_dir_nx_s = is_rev_s;
`endif
                        if (dir_break_s || lock_hit_s) begin
                            run_nx_s = {RW{1'b0}};
                        end else begin
                            run_nx_s = run_r + RW'(1'b1);
                        end
                    end else begin
                        pos_nx_s = idx_s;
                        run_nx_s = {RW{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    if (is_hold_s) begin
                        pos_nx_s = pos_r;
                    end else if (adv_s) begin
                        pos_nx_s  = idx_s;
                        step_nx_s = 1'b1;
`ifdef MONITOR_REVERSE_EN
                        dir_nx_s  = is_rev_s;
`endif
                        if (wrap_s) begin
                            sweeps_nx_s = sweeps_r + CNT_W'(1'b1);
                        end else begin
                            sweeps_nx_s = sweeps_r;
                        end
                    end else begin
                        err_nx_s = 1'b1;
                        run_nx_s = {RW{1'b0}};
                        if (err_count_r == {CNT_W{1'b1}}) begin
                            err_count_nx_s = err_count_r;
                        end else begin
                            err_count_nx_s = err_count_r + CNT_W'(1'b1);
                        end
                        if (legal_s) begin
                            pos_nx_s = idx_s;
                        end else begin
                            pos_nx_s = pos_r;
                        end
                    end
                end
                default: begin
                    run_nx_s = {RW{1'b0}};
                end
            endcase
        end else begin
            step_nx_s = 1'b0;
        end
    end

    assign POS       = pos_r;
    assign LOCKED    = (state_r == ST_LOCKED);
    assign STEP      = step_r;
    assign ERR       = err_r;
    assign ERR_COUNT = err_count_r;
    assign SWEEPS    = sweeps_r;
`ifdef MONITOR_REVERSE_EN
    assign DIR       = dir_r;
`else
    assign DIR       = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_monitor.sv
// -----------------------------------------------------------------------------
// tb_johnson_monitor
//
// Self-checking bench for johnson_monitor (default parameters). A behavioural
// model tracks position as an integer, decodes codes by table lookup into a
// ring built by simulating the chaser shift register, and applies the lock /
// error / sweep rules with modular arithmetic. Directed scenarios are followed
// by a randomized run with a mid-sequence asynchronous reset.
// -----------------------------------------------------------------------------
module tb_johnson_monitor;

    localparam int W        = 7;
    localparam int N        = 2 * W;
    localparam int PW       = 4;
    localparam int LOCK_LEN = 2;
`ifdef MONITOR_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          ENABLE;
    logic          SAMPLE;
    logic [W-1:0]  CODE_IN;
    logic [PW-1:0] POS;
    logic          LOCKED;
    logic          STEP;
    logic          ERR;
    logic [7:0]    ERR_COUNT;
    logic [7:0]    SWEEPS;
    logic          DIR;

    always #5 CLK = ~CLK;

    johnson_monitor #(.WIDTH(W), .LOCK_LEN(LOCK_LEN), .CNT_W(8)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .ENABLE   (ENABLE),
        .SAMPLE   (SAMPLE),
        .CODE_IN  (CODE_IN),
        .POS      (POS),
        .LOCKED   (LOCKED),
        .STEP     (STEP),
        .ERR      (ERR),
        .ERR_COUNT(ERR_COUNT),
        .SWEEPS   (SWEEPS),
        .DIR      (DIR)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [W-1:0] tab [N];

    int m_pos, m_run, m_errcnt, m_sweeps;
    bit m_locked, m_step, m_err, m_dir, m_rdir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int find_idx(input logic [W-1:0] c);
        for (int i = 0; i < N; i++) begin
            if (tab[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_run = 0; m_errcnt = 0; m_sweeps = 0;
        m_locked = 0; m_step = 0; m_err = 0; m_dir = 0; m_rdir = 0;
    endtask

    task automatic model_sample(input logic [W-1:0] code);
        int idx, succ, pred;
        bit fwd, rev;
        idx  = find_idx(code);
        succ = (m_pos + 1) % N;
        pred = (m_pos + N - 1) % N;
        fwd  = (idx == succ);
        rev  = REV && (idx == pred);
        if (!m_locked) begin
            if (idx < 0) begin
                m_run = 0;
            end else if (idx == m_pos) begin
                m_run = m_run;
            end else if (fwd || rev) begin
                m_pos = idx;
                if (m_run > 0 && m_rdir != rev) begin
                    m_run  = 0;
                    m_rdir = rev;
                end else begin
                    m_run++;
                    m_rdir = rev;
                    if (m_run == LOCK_LEN) begin
                        m_locked = 1;
                        m_run    = 0;
                    end
                end
            end else begin
                m_pos = idx;
                m_run = 0;
            end
        end else begin
            if (idx == m_pos) begin
                m_step = 0;
            end else if (fwd || rev) begin
                m_step = 1;
                m_dir  = rev;
                if ((fwd && idx == 0) || (rev && idx == N - 1)) m_sweeps = (m_sweeps + 1) % 256;
                m_pos = idx;
            end else begin
                m_err    = 1;
                m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
                m_locked = 0;
                m_run    = 0;
                if (idx >= 0) m_pos = idx;
            end
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".pos"},    32'(POS),       32'(m_pos));
        chk({where, ".locked"}, 32'(LOCKED),    32'(m_locked));
        chk({where, ".step"},   32'(STEP),      32'(m_step));
        chk({where, ".err"},    32'(ERR),       32'(m_err));
        chk({where, ".errcnt"}, 32'(ERR_COUNT), 32'(m_errcnt));
        chk({where, ".sweeps"}, 32'(SWEEPS),    32'(m_sweeps));
        chk({where, ".dir"},    32'(DIR),       32'(m_dir));
    endtask

    // One clock cycle: drive inputs, let the edge happen, update model, compare.
    task automatic cyc(input logic en, input logic smp, input logic [W-1:0] code);
        ENABLE  = en;
        SAMPLE  = smp;
        CODE_IN = code;
        @(posedge CLK);
        #1;
        m_step = 0;
        if (en && smp) model_sample(code);
        check_all("cyc");
    endtask

    task automatic advance_to(input int target);
        for (int g = 0; g < 40; g++) begin
            if (m_locked && m_pos == target) break;
            cyc(1'b1, 1'b1, tab[(m_pos + 1) % N]);
        end
        chk("reach_pos", 32'(POS), 32'(target));
        chk("reach_lock", 32'(LOCKED), 32'd1);
    endtask

    task automatic relock_and_break();
        for (int g = 0; g < 10; g++) begin
            if (m_locked) break;
            cyc(1'b1, 1'b1, tab[(m_pos + 1) % N]);
        end
        cyc(1'b1, 1'b1, 7'b1010101);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] c;
        int steps;
        int r;

        c = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            tab[i] = c;
            c = {~c[0], c[W-1:1]};
        end

        RSTn = 1'b0; ENABLE = 1'b0; SAMPLE = 1'b0; CODE_IN = {W{1'b0}};
        model_reset();
        #12;
        check_all("reset");
        chk("reset_pos", 32'(POS), 32'd0);
        chk("reset_locked", 32'(LOCKED), 32'd0);
        RSTn = 1'b1;

        // Lock acquisition from the reset position
        cyc(1'b0, 1'b0, {W{1'b0}});
        cyc(1'b1, 1'b1, 7'b0000000);
        cyc(1'b1, 1'b1, 7'b1000000);
        chk("lock_early", 32'(LOCKED), 32'd0);
        cyc(1'b1, 1'b1, 7'b1100000);
        chk("lock_locked", 32'(LOCKED), 32'd1);
        chk("lock_pos", 32'(POS), 32'd2);
        chk("lock_err", 32'(ERR), 32'd0);

        // Full sweep back to position 2
        steps = 0;
        for (int k = 3; k <= N + 2; k++) begin
            cyc(1'b1, 1'b1, tab[k % N]);
            if (STEP) steps++;
        end
        chk("sweep_steps", 32'(steps), 32'd14);
        chk("sweep_count", 32'(SWEEPS), 32'd1);
        chk("sweep_pos", 32'(POS), 32'd2);

        // Illegal code breaks lock, then relock
        advance_to(5);
        cyc(1'b1, 1'b1, 7'b1011000);
        chk("brk_locked", 32'(LOCKED), 32'd0);
        chk("brk_err", 32'(ERR), 32'd1);
        chk("brk_cnt", 32'(ERR_COUNT), 32'd1);
        chk("brk_pos", 32'(POS), 32'd5);
        cyc(1'b1, 1'b1, 7'b1111110);
        cyc(1'b1, 1'b1, 7'b1111111);
        chk("relock_locked", 32'(LOCKED), 32'd1);
        chk("relock_pos", 32'(POS), 32'd7);

        // Hold codes and disabled sample
        advance_to(3);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 7'b1110000);
            chk("hold_step", 32'(STEP), 32'd0);
        end
        chk("hold_pos", 32'(POS), 32'd3);
        chk("hold_cnt", 32'(ERR_COUNT), 32'd1);
        cyc(1'b0, 1'b1, 7'b0000001);
        chk("dis_pos", 32'(POS), 32'd3);
        chk("dis_locked", 32'(LOCKED), 32'd1);
        chk("dis_cnt", 32'(ERR_COUNT), 32'd1);

        // Predecessor from position 0
        advance_to(0);
        chk("pre_sweeps", 32'(SWEEPS), 32'd3);
        cyc(1'b1, 1'b1, 7'b0000001);
        if (REV) begin
            chk("rev_pos", 32'(POS), 32'd13);
            chk("rev_dir", 32'(DIR), 32'd1);
            chk("rev_step", 32'(STEP), 32'd1);
            chk("rev_sweeps", 32'(SWEEPS), 32'd4);
        end else begin
            chk("rev_err", 32'(ERR), 32'd1);
            chk("rev_locked", 32'(LOCKED), 32'd0);
            chk("rev_cnt", 32'(ERR_COUNT), 32'd2);
            chk("rev_dir", 32'(DIR), 32'd0);
        end

        // Error counter saturation
        for (int g = 0; g < 400; g++) begin
            if (m_errcnt >= 255) break;
            relock_and_break();
        end
        chk("sat_cnt", 32'(ERR_COUNT), 32'hFF);
        relock_and_break();
        relock_and_break();
        chk("sat_hold", 32'(ERR_COUNT), 32'hFF);

        // Randomized run with one asynchronous reset mid-sample
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                ENABLE  = 1'b1;
                SAMPLE  = 1'b1;
                CODE_IN = tab[(m_pos + 1) % N];
                #2;
                RSTn = 1'b0;
                #1;
                model_reset();
                check_all("async_rst");
                chk("async_rst_cnt", 32'(ERR_COUNT), 32'd0);
                @(posedge CLK);
                #1;
                check_all("rst_hold");
                RSTn   = 1'b1;
                SAMPLE = 1'b0;
            end
            r = int'($urandom_range(0, 15));
            if (r < 9)       c = tab[(m_pos + 1) % N];
            else if (r < 11) c = tab[m_pos];
            else if (r < 12) c = tab[(m_pos + N - 1) % N];
            else if (r < 14) c = tab[$urandom_range(0, N - 1)];
            else             c = W'($urandom);
            cyc(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, c);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
